// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MEM pipeline stage. Issues one data-memory access per
//               load/store over a valid/ready handshake, aligns store data,
//               extends load data and registers the MEM/WB bundle.
// Revision    : 1.0  initial release
// ============================================================================
module mem_stage #(
  parameter logic [4:0] OP_LOAD  = 5'b00000,
  parameter logic [4:0] OP_STORE = 5'b01000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IM_stall,
  input  logic [4:0]  M_op,
  input  logic [2:0]  M_func3,
  input  logic [4:0]  M_rd,
  input  logic [31:0] M_aluOut,
  input  logic [31:0] M_rs2_data,
  output logic        dm_req_valid,
  input  logic        dm_req_ready,
  output logic        dm_req_we,
  output logic [31:0] dm_req_addr,
  output logic [3:0]  dm_req_wstrb,
  output logic [31:0] dm_req_wdata,
  input  logic        dm_resp_valid,
  input  logic [31:0] dm_resp_rdata,
  output logic        DM_stall,
  output logic [4:0]  W_op,
  output logic [4:0]  W_rd,
  output logic [31:0] W_aluOut,
  output logic [31:0] W_ld_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        is_store, is_load, mem_op, advance, capture, req_valid;
  logic [1:0]  byte_off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext, ld_data;

  // A load to x0 is a bubble, so the all-zero reset bundle never reaches memory
  assign is_store = (M_op == OP_STORE);
  assign is_load  = (M_op == OP_LOAD) && (M_rd != 5'd0);
  assign mem_op   = is_store || is_load;
  assign byte_off = M_aluOut[1:0];

  assign DM_stall = mem_op && (state != DONE);
  assign advance  = !(IM_stall || DM_stall);
  assign capture  = (state == RESP) && dm_resp_valid;

  assign dm_req_we   = is_store;
  assign dm_req_addr = {M_aluOut[31:2], 2'b00};

  always_comb begin
    dm_req_wstrb = 4'b0000;
    dm_req_wdata = M_rs2_data;
    if (is_store) begin
      case (M_func3[1:0])
        2'b00: begin
          dm_req_wstrb = 4'b0001 << byte_off;
          dm_req_wdata = {4{M_rs2_data[7:0]}};
        end
        2'b01: begin
          dm_req_wstrb = M_aluOut[1] ? 4'b1100 : 4'b0011;
          dm_req_wdata = {2{M_rs2_data[15:0]}};
        end
        default: dm_req_wstrb = 4'b1111;
      endcase
    end
  end

  assign ld_byte = dm_resp_rdata[{byte_off, 3'b000} +: 8];
  assign ld_half = dm_resp_rdata[{M_aluOut[1], 4'b0000} +: 16];

  always_comb begin
    case (M_func3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dm_resp_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    case (state)
      IDLE: begin
        req_valid = mem_op;
        if (mem_op) state_nxt = dm_req_ready ? RESP : REQ;
      end
      REQ: begin
        req_valid = 1'b1;
        if (dm_req_ready) state_nxt = RESP;
      end
      RESP: if (dm_resp_valid) state_nxt = DONE;
      DONE: if (!IM_stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset must silence the request in the same cycle, before the state settles
  assign dm_req_valid = req_valid && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ld_data   <= 32'd0;
      W_op      <= 5'd0;
      W_rd      <= 5'd0;
      W_aluOut  <= 32'd0;
      W_ld_data <= 32'd0;
    end else begin
      state <= state_nxt;
      if (capture) ld_data <= ld_ext;
      if (advance) begin
        W_op      <= M_op;
        W_rd      <= M_rd;
        W_aluOut  <= M_aluOut;
        W_ld_data <= (M_op == OP_LOAD) ? ld_data : 32'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed plus randomized checks of mem_stage against a
//               behavioural memory/pipeline reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IM_stall;
  logic [4:0]  M_op;
  logic [2:0]  M_func3;
  logic [4:0]  M_rd;
  logic [31:0] M_aluOut, M_rs2_data;
  logic        dm_req_valid, dm_req_ready, dm_req_we;
  logic [31:0] dm_req_addr, dm_req_wdata;
  logic [3:0]  dm_req_wstrb;
  logic        dm_resp_valid;
  logic [31:0] dm_resp_rdata;
  logic        DM_stall;
  logic [4:0]  W_op, W_rd;
  logic [31:0] W_aluOut, W_ld_data;

  int checks = 0;
  int failures = 0;

  logic [4:0]  exp_wop, exp_wrd;
  logic [31:0] exp_walu, exp_wld, cap;

  mem_stage #(.OP_LOAD(OP_LOAD), .OP_STORE(OP_STORE)) dut (
    .clk(clk), .rst_n(rst_n), .IM_stall(IM_stall),
    .M_op(M_op), .M_func3(M_func3), .M_rd(M_rd),
    .M_aluOut(M_aluOut), .M_rs2_data(M_rs2_data),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
    .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr),
    .dm_req_wstrb(dm_req_wstrb), .dm_req_wdata(dm_req_wdata),
    .dm_resp_valid(dm_resp_valid), .dm_resp_rdata(dm_resp_rdata),
    .DM_stall(DM_stall), .W_op(W_op), .W_rd(W_rd),
    .W_aluOut(W_aluOut), .W_ld_data(W_ld_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag);
    chk({tag, "_W_op"}, {27'd0, W_op}, {27'd0, exp_wop});
    chk({tag, "_W_rd"}, {27'd0, W_rd}, {27'd0, exp_wrd});
    chk({tag, "_W_aluOut"}, W_aluOut, exp_walu);
    chk({tag, "_W_ld_data"}, W_ld_data, exp_wld);
  endtask

  // Reference load extension: plain arithmetic on the selected byte/halfword
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // One instruction through MEM: nwait ready-low cycles, rdly idle response
  // cycles, then imst cycles of IM_stall while the stage sits in DONE.
  task automatic do_op(input logic [4:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] word,
                       input int nwait, input int rdly, input int imst);
    logic        st, mem;
    logic [3:0]  estrb;
    logic [31:0] ewdata, b, h;
    int          acc;
    st  = (op == OP_STORE);
    mem = st || ((op == OP_LOAD) && (rd != 5'd0));
    b = rs2 & 32'hFF;
    h = rs2 & 32'hFFFF;
    case (f3[1:0])
      2'd0:    begin estrb = 4'(1 << alu[1:0]);     ewdata = b * 32'h01010101; end
      2'd1:    begin estrb = 4'(3 << (alu[1] * 2)); ewdata = h * 32'h00010001; end
      default: begin estrb = 4'hF;                  ewdata = rs2;              end
    endcase
    if (!st) estrb = 4'h0;
    M_op = op; M_func3 = f3; M_rd = rd; M_aluOut = alu; M_rs2_data = rs2;
    IM_stall = 1'b0; dm_resp_valid = 1'b0;
    acc = 0;
    if (mem) begin
      for (int c = 0; c <= nwait; c++) begin
        dm_req_ready = (c == nwait);
        @(negedge clk);
        chk("req_valid", {31'd0, dm_req_valid}, 32'd1);
        chk("req_addr", dm_req_addr, alu & 32'hFFFFFFFC);
        chk("req_we", {31'd0, dm_req_we}, {31'd0, st});
        chk("req_wstrb", {28'd0, dm_req_wstrb}, {28'd0, estrb});
        if (st) chk("req_wdata", dm_req_wdata, ewdata);
        chk("req_stall", {31'd0, DM_stall}, 32'd1);
        chk_w("req_hold");
        if (dm_req_valid && dm_req_ready) acc++;
        @(posedge clk); #1;
      end
      for (int d = 0; d <= rdly; d++) begin
        dm_req_ready  = 1'($urandom);
        dm_resp_valid = (d == rdly);
        dm_resp_rdata = (d == rdly) ? word : $urandom;
        @(negedge clk);
        chk("resp_valid_low", {31'd0, dm_req_valid}, 32'd0);
        chk("resp_stall", {31'd0, DM_stall}, 32'd1);
        if (dm_req_valid && dm_req_ready) acc++;
        @(posedge clk); #1;
      end
      dm_resp_valid = 1'b0;
      dm_resp_rdata = $urandom;
      cap = ref_load(f3, alu, word);
    end
    for (int s = 0; s <= imst; s++) begin
      IM_stall     = (s < imst);
      dm_req_ready = 1'b1;
      @(negedge clk);
      chk("done_valid_low", {31'd0, dm_req_valid}, 32'd0);
      chk("done_stall", {31'd0, DM_stall}, 32'd0);
      chk_w("done_hold");
      if (dm_req_valid && dm_req_ready) acc++;
      @(posedge clk); #1;
    end
    IM_stall = 1'b0;
    dm_req_ready = 1'b0;
    chk("accepted_reqs", acc, mem ? 32'd1 : 32'd0);
    exp_wop = op; exp_wrd = rd; exp_walu = alu;
    exp_wld = (op == OP_LOAD) ? cap : 32'd0;
    chk_w("wb");
  endtask

  int         r, nw, rdl, ims;
  logic [4:0] rop;
  logic [2:0] rf3;
  int         lf3 [6] = '{0, 1, 2, 4, 5, 3};

  initial begin
    rst_n = 1'b0; IM_stall = 1'b0;
    M_op = '0; M_func3 = '0; M_rd = '0; M_aluOut = '0; M_rs2_data = '0;
    dm_req_ready = 1'b0; dm_resp_valid = 1'b0; dm_resp_rdata = '0;
    exp_wop = '0; exp_wrd = '0; exp_walu = '0; exp_wld = '0; cap = '0;
    #12;
    chk("rst_valid", {31'd0, dm_req_valid}, 32'd0);
    chk("rst_stall", {31'd0, DM_stall}, 32'd0);
    chk_w("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(OP_LOAD, 3'd2, 5'd5, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    do_op(OP_LOAD, 3'd0, 5'd6, 32'h103, 32'h0, 32'h80123456, 0, 0, 0);
    chk("lb_sign", W_ld_data, 32'hFFFFFF80);
    do_op(OP_LOAD, 3'd4, 5'd6, 32'h103, 32'h0, 32'h80123456, 0, 0, 0);
    chk("lbu_zero", W_ld_data, 32'h00000080);
    do_op(OP_LOAD, 3'd5, 5'd7, 32'h102, 32'h0, 32'hBEEF1234, 0, 0, 0);
    chk("lhu_zero", W_ld_data, 32'h0000BEEF);
    do_op(OP_STORE, 3'd0, 5'd0, 32'h202, 32'h123456AB, 32'h0, 0, 0, 0);
    do_op(OP_STORE, 3'd1, 5'd0, 32'h202, 32'h123456AB, 32'h0, 0, 0, 0);
    do_op(OP_STORE, 3'd2, 5'd0, 32'h204, 32'hCAFEBABE, 32'h0, 3, 0, 0);
    do_op(OP_LOAD, 3'd1, 5'd9, 32'h306, 32'h0, 32'h8001ABCD, 1, 2, 3);
    do_op(5'b01100, 3'd0, 5'd3, 32'h55AA55AA, 32'h0, 32'h0, 0, 0, 2);
    do_op(5'b00000, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0);

    // Reset while the access waits for its response
    M_op = OP_LOAD; M_func3 = 3'd2; M_rd = 5'd7; M_aluOut = 32'h300;
    dm_req_ready = 1'b1;
    @(posedge clk); #1;
    dm_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, dm_req_valid}, 32'd0);
    exp_wop = '0; exp_wrd = '0; exp_walu = '0; exp_wld = '0; cap = '0;
    chk_w("midrst");
    M_op = '0; M_func3 = '0; M_rd = '0; M_aluOut = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    dm_resp_valid = 1'b1; dm_resp_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("late_resp_valid", {31'd0, dm_req_valid}, 32'd0);
    chk("late_resp_stall", {31'd0, DM_stall}, 32'd0);
    @(posedge clk); #1;
    dm_resp_valid = 1'b0;
    @(posedge clk); #1;
    chk_w("late_resp");

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      begin rop = OP_LOAD;  rf3 = 3'(lf3[$urandom_range(0, 5)]); end
      else if (r < 7) begin rop = OP_STORE; rf3 = 3'($urandom_range(0, 2)); end
      else            begin rop = r[0] ? 5'b01100 : 5'b00100; rf3 = 3'($urandom); end
      nw  = $urandom_range(0, 3);
      rdl = $urandom_range(0, 2);
      ims = $urandom_range(0, 2);
      do_op(rop, rf3, 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, nw, rdl, ims);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
